// File: rtl/computer_pkg.sv
// Shared definitions for the computer datapath.
// Read-return owner tags and default RAM port widths.
package computer_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_PROC = 2'd1,
        OWNER_DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two RAM requesters, the RAM and the arbiter.
// master = requester/RAM side, slave = arbiter side.
interface data_memory_arbiter_if #(
    parameter int ADDR_WIDTH = computer_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = computer_pkg::DATA_WIDTH
);
    logic                  proc_req;
    logic                  proc_write;
    logic [ADDR_WIDTH-1:0] proc_address;
    logic [DATA_WIDTH-1:0] proc_write_value;
    logic                  proc_grant;
    logic                  proc_read_valid;
    logic [DATA_WIDTH-1:0] proc_read_value;

    logic                  dbg_req;
    logic                  dbg_write;
    logic [ADDR_WIDTH-1:0] dbg_address;
    logic [DATA_WIDTH-1:0] dbg_write_value;
    logic                  dbg_grant;
    logic                  dbg_read_valid;
    logic [DATA_WIDTH-1:0] dbg_read_value;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_value;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_read_value;

    logic                  starved;

    modport master (
        output proc_req, proc_write, proc_address, proc_write_value,
        input  proc_grant, proc_read_valid, proc_read_value,
        output dbg_req, dbg_write, dbg_address, dbg_write_value,
        input  dbg_grant, dbg_read_valid, dbg_read_value,
        input  mem_address, mem_write_value, mem_write_enable,
        output mem_read_value,
        input  starved
    );

    modport slave (
        input  proc_req, proc_write, proc_address, proc_write_value,
        output proc_grant, proc_read_valid, proc_read_value,
        input  dbg_req, dbg_write, dbg_address, dbg_write_value,
        output dbg_grant, dbg_read_valid, dbg_read_value,
        output mem_address, mem_write_value, mem_write_enable,
        input  mem_read_value,
        output starved
    );

endinterface

// File: rtl/starvation_counter.sv
// Saturating counter with clear; counts debug-blocked processor grants.
// o_at_max flags the cycle where debug must be forced through.
module starvation_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_count,
    output logic          o_at_max
);

    logic [CW-1:0] r_count;

    // Clear dominates; increment stops at MAX_WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == CW'(MAX_WAIT));

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single data-RAM port between processor and debug/loader.
// Processor has priority; debug is forced through after MAX_WAIT losses.
module data_memory_arbiter #(
    parameter int ADDR_WIDTH = computer_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = computer_pkg::DATA_WIDTH,
    parameter int MAX_WAIT   = 4
) (
    input logic                 clock,
    input logic                 reset,
    data_memory_arbiter_if.slave bus
);
    import computer_pkg::*;

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic                  w_dbg_win;
    logic                  w_proc_win;
    logic                  w_at_max;
    logic                  w_inc;
    logic                  w_clr;
    logic [CW-1:0]         w_wait_count;
    owner_e                w_rd_owner_nxt;
    owner_e                r_rd_owner;
    logic [DATA_WIDTH-1:0] r_proc_hold;
    logic [DATA_WIDTH-1:0] r_dbg_hold;

    // Per-cycle arbitration, RAM mux and read-tag selection.
    always_comb begin
        w_dbg_win  = reset & bus.dbg_req & (~bus.proc_req | w_at_max);
        w_proc_win = reset & bus.proc_req & ~w_dbg_win;

        bus.mem_address     = bus.proc_address;
        bus.mem_write_value = bus.proc_write_value;
        if (w_dbg_win) begin
            bus.mem_address     = bus.dbg_address;
            bus.mem_write_value = bus.dbg_write_value;
        end
        bus.mem_write_enable = (w_dbg_win & bus.dbg_write)
                             | (w_proc_win & bus.proc_write);

        w_rd_owner_nxt = OWNER_NONE;
        if (w_dbg_win && !bus.dbg_write) begin
            w_rd_owner_nxt = OWNER_DBG;
        end else if (w_proc_win && !bus.proc_write) begin
            w_rd_owner_nxt = OWNER_PROC;
        end

        w_inc = w_proc_win & bus.dbg_req;
        w_clr = w_dbg_win | ~bus.dbg_req;
    end

    assign bus.proc_grant = w_proc_win;
    assign bus.dbg_grant  = w_dbg_win;
    assign bus.starved    = w_dbg_win & bus.proc_req;

    starvation_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (CW)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .o_count  (w_wait_count),
        .o_at_max (w_at_max)
    );

    // Remember who issued this cycle's read so the data returns to them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_owner <= OWNER_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // Keep each side's last returned data while the RAM serves the other.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_proc_hold <= '0;
            r_dbg_hold  <= '0;
        end else begin
            if (r_rd_owner == OWNER_PROC) begin
                r_proc_hold <= bus.mem_read_value;
            end
            if (r_rd_owner == OWNER_DBG) begin
                r_dbg_hold <= bus.mem_read_value;
            end
        end
    end

    assign bus.proc_read_valid = (r_rd_owner == OWNER_PROC);
    assign bus.dbg_read_valid  = (r_rd_owner == OWNER_DBG);
    assign bus.proc_read_value = bus.proc_read_valid
                               ? bus.mem_read_value : r_proc_hold;
    assign bus.dbg_read_value  = bus.dbg_read_valid
                               ? bus.mem_read_value : r_dbg_hold;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed testbench for data_memory_arbiter with a 1-cycle RAM model.
// Inputs change on the falling edge; outputs are sampled away from edges.
module tb_data_memory_arbiter;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    data_memory_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    data_memory_arbiter #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .MAX_WAIT   (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [0:1023];
    logic [31:0] ram_q;

    always @(posedge clock) begin
        if (bus.mem_write_enable) ram[bus.mem_address] <= bus.mem_write_value;
        ram_q <= ram[bus.mem_address];
    end

    assign bus.mem_read_value = ram_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic pr, input logic pw,
                         input logic [9:0] pa, input logic [31:0] pv,
                         input logic dr, input logic dw,
                         input logic [9:0] da, input logic [31:0] dv);
        bus.proc_req         = pr;
        bus.proc_write       = pw;
        bus.proc_address     = pa;
        bus.proc_write_value = pv;
        bus.dbg_req          = dr;
        bus.dbg_write        = dw;
        bus.dbg_address      = da;
        bus.dbg_write_value  = dv;
    endtask

    task automatic test_reset();
        @(negedge clock);
        drive(1, 1, 10'h005, 32'h1111_1111, 1, 1, 10'h006, 32'h2222_2222);
        #1;
        total++;
        if (bus.proc_grant !== 1'b0) begin
            bad++; $display("FAIL rst_pgrant got=%b exp=0", bus.proc_grant);
        end
        total++;
        if (bus.dbg_grant !== 1'b0) begin
            bad++; $display("FAIL rst_dgrant got=%b exp=0", bus.dbg_grant);
        end
        total++;
        if (bus.mem_write_enable !== 1'b0) begin
            bad++; $display("FAIL rst_we got=%b exp=0", bus.mem_write_enable);
        end
        total++;
        if (bus.proc_read_valid !== 1'b0 || bus.dbg_read_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b%b exp=00",
                            bus.proc_read_valid, bus.dbg_read_valid);
        end
        total++;
        if (bus.proc_read_value !== 32'h0 || bus.dbg_read_value !== 32'h0) begin
            bad++; $display("FAIL rst_value got=%h/%h exp=0/0",
                            bus.proc_read_value, bus.dbg_read_value);
        end
        @(negedge clock);
        reset = 1'b1;
        drive(1, 0, 10'h005, 32'h0, 1, 0, 10'h006, 32'h0);
        #1;
        total++;
        if (bus.proc_grant !== 1'b1 || bus.dbg_grant !== 1'b0) begin
            bad++; $display("FAIL rel_first got=p%b d%b exp=p1 d0",
                            bus.proc_grant, bus.dbg_grant);
        end
        @(posedge clock);
        #1;
        total++;
        if (bus.proc_read_valid !== 1'b1) begin
            bad++; $display("FAIL rel_pvalid got=%b exp=1", bus.proc_read_valid);
        end
        @(negedge clock);
        drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    endtask

    task automatic test_proc_read();
        @(negedge clock);
        drive(1, 1, 10'h005, 32'hDEAD_BEEF, 0, 0, 10'h0, 32'h0);
        #1;
        total++;
        if (bus.proc_grant !== 1'b1 || bus.mem_write_enable !== 1'b1 ||
            bus.mem_address !== 10'h005) begin
            bad++; $display("FAIL pwr_grant got=g%b we%b a%h exp=g1 we1 a005",
                            bus.proc_grant, bus.mem_write_enable,
                            bus.mem_address);
        end
        @(posedge clock);
        #1;
        total++;
        if (bus.proc_read_valid !== 1'b0) begin
            bad++; $display("FAIL pwr_novalid got=%b exp=0", bus.proc_read_valid);
        end
        @(negedge clock);
        drive(1, 0, 10'h005, 32'h0, 0, 0, 10'h0, 32'h0);
        #1;
        total++;
        if (bus.proc_grant !== 1'b1 || bus.mem_write_enable !== 1'b0) begin
            bad++; $display("FAIL prd_grant got=g%b we%b exp=g1 we0",
                            bus.proc_grant, bus.mem_write_enable);
        end
        @(posedge clock);
        #1;
        total++;
        if (bus.proc_read_valid !== 1'b1 ||
            bus.proc_read_value !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL prd_data got=v%b %h exp=v1 deadbeef",
                            bus.proc_read_valid, bus.proc_read_value);
        end
        total++;
        if (bus.dbg_read_valid !== 1'b0 || bus.dbg_grant !== 1'b0) begin
            bad++; $display("FAIL prd_dbgidle got=v%b g%b exp=v0 g0",
                            bus.dbg_read_valid, bus.dbg_grant);
        end
        @(negedge clock);
        drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    endtask

    task automatic test_dbg_write_proc_read();
        @(negedge clock);
        drive(0, 0, 10'h0, 32'h0, 1, 1, 10'h3FF, 32'h1234_5678);
        #1;
        total++;
        if (bus.dbg_grant !== 1'b1 || bus.mem_write_enable !== 1'b1 ||
            bus.mem_address !== 10'h3FF ||
            bus.mem_write_value !== 32'h1234_5678) begin
            bad++; $display("FAIL dwr_bus got=g%b we%b a%h d%h exp=g1 we1 a3ff d12345678",
                            bus.dbg_grant, bus.mem_write_enable,
                            bus.mem_address, bus.mem_write_value);
        end
        @(negedge clock);
        drive(1, 0, 10'h3FF, 32'h0, 0, 0, 10'h0, 32'h0);
        #1;
        total++;
        if (bus.mem_write_enable !== 1'b0 || bus.proc_grant !== 1'b1) begin
            bad++; $display("FAIL dwr_once got=we%b g%b exp=we0 g1",
                            bus.mem_write_enable, bus.proc_grant);
        end
        @(posedge clock);
        #1;
        total++;
        if (bus.proc_read_valid !== 1'b1 ||
            bus.proc_read_value !== 32'h1234_5678) begin
            bad++; $display("FAIL dwr_readback got=v%b %h exp=v1 12345678",
                            bus.proc_read_valid, bus.proc_read_value);
        end
        total++;
        if (bus.dbg_read_valid !== 1'b0) begin
            bad++; $display("FAIL dwr_dnovalid got=%b exp=0", bus.dbg_read_valid);
        end
        @(negedge clock);
        drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    endtask

    task automatic test_contention();
        logic exp_d;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(1, 0, 10'h005, 32'h0, 1, 0, 10'h3FF, 32'h0);
            #1;
            exp_d = (i % 5 == 4);
            total++;
            if (bus.dbg_grant !== exp_d || bus.proc_grant !== !exp_d ||
                bus.starved !== exp_d) begin
                bad++; $display("FAIL cont_grant[%0d] got=p%b d%b s%b exp=p%b d%b s%b",
                                i, bus.proc_grant, bus.dbg_grant, bus.starved,
                                !exp_d, exp_d, exp_d);
            end
            @(posedge clock);
            #1;
            total++;
            if (exp_d) begin
                if (bus.dbg_read_valid !== 1'b1 || bus.proc_read_valid !== 1'b0 ||
                    bus.dbg_read_value !== 32'h1234_5678 ||
                    bus.proc_read_value !== 32'hDEAD_BEEF) begin
                    bad++; $display("FAIL cont_route[%0d] got=pv%b dv%b %h/%h exp=pv0 dv1 deadbeef/12345678",
                                    i, bus.proc_read_valid, bus.dbg_read_valid,
                                    bus.proc_read_value, bus.dbg_read_value);
                end
            end else begin
                if (bus.proc_read_valid !== 1'b1 || bus.dbg_read_valid !== 1'b0 ||
                    bus.proc_read_value !== 32'hDEAD_BEEF) begin
                    bad++; $display("FAIL cont_route[%0d] got=pv%b dv%b %h exp=pv1 dv0 deadbeef",
                                    i, bus.proc_read_valid, bus.dbg_read_valid,
                                    bus.proc_read_value);
                end
            end
        end
        @(negedge clock);
        drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock);
        drive(0, 0, 10'h0, 32'h0, 1, 0, 10'h3FF, 32'h0);
        #1;
        total++;
        if (bus.dbg_grant !== 1'b1) begin
            bad++; $display("FAIL mid_grant got=%b exp=1", bus.dbg_grant);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.dbg_req = 1'b0;
        #1;
        total++;
        if (bus.dbg_read_valid !== 1'b0) begin
            bad++; $display("FAIL mid_squash got=%b exp=0", bus.dbg_read_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (bus.dbg_read_valid !== 1'b0 || bus.dbg_read_value !== 32'h0) begin
            bad++; $display("FAIL mid_stale got=v%b %h exp=v0 0",
                            bus.dbg_read_valid, bus.dbg_read_value);
        end
        total++;
        if (dut.w_wait_count !== 3'd0) begin
            bad++; $display("FAIL mid_wait got=%0d exp=0", dut.w_wait_count);
        end
    endtask

    task automatic test_dbg_drop();
        logic [8:0] dreq;
        logic [8:0] dgnt;
        dreq = 9'b1_1111_0111;
        dgnt = 9'b1_0000_0000;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            drive(1, 0, 10'h005, 32'h0, dreq[i], 0, 10'h3FF, 32'h0);
            #1;
            total++;
            if (bus.dbg_grant !== dgnt[i] || bus.proc_grant !== !dgnt[i]) begin
                bad++; $display("FAIL drop_grant[%0d] got=p%b d%b exp=p%b d%b",
                                i, bus.proc_grant, bus.dbg_grant,
                                !dgnt[i], dgnt[i]);
            end
        end
        @(negedge clock);
        drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
        test_reset();
        test_proc_read();
        test_dbg_write_proc_read();
        test_contention();
        test_reset_mid_read();
        test_dbg_drop();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
